regfile_write_sched: RTL and testbench
======================================

Name: regfile_write_sched

Overview:
- Write scheduler for a bank of NREGS CE/RESET-controlled 32-bit registers (register init value 1).
- Shares the bank's single write path between two requesters, A and B, using valid/ready handshakes and round-robin arbitration.
- Also sequences a bank clear: it drives each register's sync RESET one register per cycle, so every register returns to its init value.
- Sits between the requesting datapath stages and the register bank; drives only the bank's CE, RESET and I inputs.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 4, number of registers in the bank (2..16).
- ADDR_W, localparam = max(1, clog2(NREGS)), register address width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a write.
- a_addr  input  ADDR_W  A target register index.
- a_data  input  WIDTH  A write data.
- a_ready  output  1  A write accepted this cycle (combinational grant).
- b_valid  input  1  requester B has a write.
- b_addr  input  ADDR_W  B target register index.
- b_data  input  WIDTH  B write data.
- b_ready  output  1  B write accepted this cycle.
- clr_req  input  1  single-cycle pulse that requests a bank clear.
- busy  output  1  high while in CLEAR state.
- clr_done  output  1  one-cycle pulse on clear completion.
- addr_err  output  1  one-cycle pulse: accepted write had addr >= NREGS and was dropped.
- reg_ce  output  NREGS  per-register CE, registered, at most one bit set.
- reg_rst  output  NREGS  per-register sync RESET, registered, at most one bit set.
- reg_wdata  output  WIDTH  shared I input of all registers, registered.

Behaviour:
- Async reset values:
  - state = IDLE; last_grant = B, so A wins the first contention.
  - reg_ce = 0, reg_rst = 0, reg_wdata = 0.
  - busy, clr_done, addr_err = 0; a_ready = b_ready = 0 while RESET is high.
- FSM states:
  - IDLE: arbitrates writes.
  - CLEAR: walks clr_idx from 0 to NREGS-1.
- IDLE arbitration (combinational):
  - Only a_valid: a_ready = 1.
  - Only b_valid: b_ready = 1.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates on every grant, contended or not.
  - At most one ready per cycle.
  - Requesters hold valid/addr/data stable until their ready is seen.
- Write latency:
  - A grant in cycle t registers reg_ce[addr] = 1 and reg_wdata = granted data for cycle t+1.
  - The register captures the data at the end of t+1; the new value is visible on its output in t+2.
  - reg_ce is 0 in every cycle without a grant in the previous cycle.
  - Back-to-back grants produce back-to-back CE pulses, with no bubble.
- Address error: a granted addr >= NREGS sets no CE bit and pulses addr_err in t+1. The handshake still completes.
- Clear request in IDLE:
  - clr_req in IDLE has priority over writes: no ready that cycle.
  - Next state CLEAR, clr_idx = 0, busy = 1 from the next cycle.
- CLEAR state:
  - Each cycle, registers reg_rst one-hot at clr_idx, then increments clr_idx.
  - a_ready = b_ready = 0 throughout.
  - After issuing index NREGS-1: return to IDLE and pulse clr_done in the same cycle as the last reg_rst pulse.
  - busy falls in the following cycle.
  - Total CLEAR occupancy is exactly NREGS cycles.
- clr_req while in CLEAR is ignored; it is not queued.
- last_grant is unchanged by a clear.
- RESET asserted mid-CLEAR or mid-write: all outputs clear immediately and no pending CE/RST is issued. The register bank's own reset is handled outside this block.

Decomposition:
- Shared package regfile_pkg:
  - state enum {IDLE, CLEAR}.
  - Requester id enum {REQ_A, REQ_B}.
  - REG_INIT_VALUE = 32'h1, for the bench model.
- One sub-module: rr_arb2 (two-way round-robin arbiter with a last_grant flop).
- The FSM, output registers and clr_idx counter stay in the top module.

Test Plan:
- Lone write: A writes addr 2, data 0xDEADBEEF, in cycle t -> a_ready = 1 in t; reg_ce = 4'b0100 and reg_wdata = 0xDEADBEEF in t+1; register 2 reads 0xDEADBEEF in t+2.
- Contention: A and B both valid for 4 cycles after reset -> grants A, B, A, B; four consecutive single-bit CE pulses with the matching data.
- Clear: clr_req with NREGS = 4 -> busy for 4 cycles; reg_rst = 0001, 0010, 0100, 1000 on successive cycles; clr_done coincides with 1000; all registers read 1.
- Clear with simultaneous valid: clr_req and a_valid in the same cycle -> a_ready = 0 for 5 cycles; A is granted in the first IDLE cycle after the clear.
- Address error: NREGS = 3, B writes addr 3 -> b_ready = 1, reg_ce = 0, addr_err pulses once; no register changes.
- Reset mid-operation: RESET asserted during the 2nd CLEAR cycle -> reg_rst = 0 and busy = 0 immediately; state is IDLE after deassertion; no clr_done pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-bank write scheduler
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    localparam logic [31:0] REG_INIT_VALUE = 32'h1;

    function automatic int addr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a last-grant flop
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    req_e last_q;
    req_e last_d;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                gnt_a_o = (last_q == REQ_B);
                gnt_b_o = (last_q == REQ_A);
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_a_o) begin
            last_d = REQ_A;
        end else if (gnt_b_o) begin
            last_d = REQ_B;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - arbitrates two writers onto a register bank and sequences bank clears
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    localparam int ADDR_W = addr_width(NREGS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_data,
    output logic              b_ready,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              addr_err,
    output logic [NREGS-1:0]  reg_ce,
    output logic [NREGS-1:0]  reg_rst,
    output logic [WIDTH-1:0]  reg_wdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [NREGS-1:0]  reg_ce_q, reg_ce_d;
    logic [NREGS-1:0]  reg_rst_q, reg_rst_d;
    logic [WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
    logic              addr_err_q, addr_err_d;

    logic              arb_en;
    logic              gnt_a, gnt_b;
    logic [ADDR_W-1:0] gnt_addr;
    logic [WIDTH-1:0]  gnt_data;
    logic [31:0]       gnt_addr_ext;
    logic              gnt_addr_ok;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_idx_inc;

    // A clear request in IDLE pre-empts any write offered in the same cycle.
    assign arb_en = (state_q == IDLE) && !clr_req && !RESET;

    rr_arb2 u_arb (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .en_i    (arb_en),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_ready      = gnt_a;
    assign b_ready      = gnt_b;
    assign gnt_addr     = gnt_a ? a_addr : b_addr;
    assign gnt_data     = gnt_a ? a_data : b_data;
    assign gnt_addr_ext = 32'(gnt_addr);
    assign gnt_addr_ok  = gnt_addr_ext < 32'(NREGS);
    assign clr_last     = (clr_idx_q == ADDR_W'(NREGS - 1));
    assign clr_idx_inc  = clr_idx_q + ADDR_W'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            clr_idx_q   <= '0;
            reg_ce_q    <= '0;
            reg_rst_q   <= '0;
            reg_wdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            reg_ce_q    <= reg_ce_d;
            reg_rst_q   <= reg_rst_d;
            reg_wdata_q <= reg_wdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // clr_idx tracks the register whose RESET is on the output this cycle.
    always_comb begin
        clr_idx_d   = clr_idx_q;
        reg_ce_d    = '0;
        reg_rst_d   = '0;
        reg_wdata_d = reg_wdata_q;
        addr_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    clr_idx_d = '0;
                    reg_rst_d = NREGS'(1);
                end else if (gnt_a || gnt_b) begin
                    reg_wdata_d = gnt_data;
                    if (gnt_addr_ok) begin
                        reg_ce_d = NREGS'(1) << gnt_addr;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_inc;
                    reg_rst_d = NREGS'(1) << clr_idx_inc;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == CLEAR);
    assign clr_done  = (state_q == CLEAR) && clr_last;
    assign addr_err  = addr_err_q;
    assign reg_ce    = reg_ce_q;
    assign reg_rst   = reg_rst_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - scoreboard bench for regfile_write_sched
module tb_regfile_write_sched;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tb_init;

    logic        a4_valid, a4_ready, b4_valid, b4_ready;
    logic [1:0]  a4_addr, b4_addr;
    logic [31:0] a4_data, b4_data, wd4;
    logic        clr4, busy4, done4, err4;
    logic [3:0]  ce4, rs4;

    logic        a3_valid, a3_ready, b3_valid, b3_ready;
    logic [1:0]  a3_addr, b3_addr;
    logic [31:0] a3_data, b3_data, wd3;
    logic        clr3, busy3, done3, err3;
    logic [2:0]  ce3, rs3;

    regfile_write_sched #(.WIDTH(32), .NREGS(4)) dut4 (
        .CLK(clk), .RESET(rst),
        .a_valid(a4_valid), .a_addr(a4_addr), .a_data(a4_data), .a_ready(a4_ready),
        .b_valid(b4_valid), .b_addr(b4_addr), .b_data(b4_data), .b_ready(b4_ready),
        .clr_req(clr4), .busy(busy4), .clr_done(done4), .addr_err(err4),
        .reg_ce(ce4), .reg_rst(rs4), .reg_wdata(wd4)
    );

    regfile_write_sched #(.WIDTH(32), .NREGS(3)) dut3 (
        .CLK(clk), .RESET(rst),
        .a_valid(a3_valid), .a_addr(a3_addr), .a_data(a3_data), .a_ready(a3_ready),
        .b_valid(b3_valid), .b_addr(b3_addr), .b_data(b3_data), .b_ready(b3_ready),
        .clr_req(clr3), .busy(busy3), .clr_done(done3), .addr_err(err3),
        .reg_ce(ce3), .reg_rst(rs3), .reg_wdata(wd3)
    );

    // Behavioural register banks driven by the scheduler outputs
    logic [31:0] bank4 [4];
    logic [31:0] bank3 [3];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (tb_init || rs4[i]) bank4[i] <= REG_INIT_VALUE;
            else if (ce4[i])       bank4[i] <= wd4;
        end
        for (int i = 0; i < 3; i++) begin
            if (tb_init || rs3[i]) bank3[i] <= REG_INIT_VALUE;
            else if (ce3[i])       bank3[i] <= wd3;
        end
    end

    typedef struct packed {
        logic [3:0]  ce;
        logic [3:0]  rs;
        logic        done;
        logic        err;
        logic [31:0] wd;
    } ev_t;

    ev_t q4[$];
    ev_t q3[$];
    ev_t e4, e3;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push4(input logic [3:0] ce, input logic [3:0] rs, input logic done,
                         input logic err, input logic [31:0] wd);
        q4.push_back({ce, rs, done, err, wd});
    endtask

    task automatic push3(input logic [3:0] ce, input logic err, input logic [31:0] wd);
        q3.push_back({ce, 4'b0000, 1'b0, err, wd});
    endtask

    always @(negedge clk) begin
        if (!rst && ((|ce4) || (|rs4) || done4 || err4)) begin
            if (q4.size() == 0) begin
                checks++;
                $display("FAIL dut4_unexpected: ce=%b rst=%b done=%b err=%b, none expected",
                         ce4, rs4, done4, err4);
            end else begin
                e4 = q4.pop_front();
                check("dut4_ce", 64'(ce4), 64'(e4.ce));
                check("dut4_rst", 64'(rs4), 64'(e4.rs));
                check("dut4_done", 64'(done4), 64'(e4.done));
                check("dut4_err", 64'(err4), 64'(e4.err));
                if (e4.ce != 4'b0) check("dut4_wdata", 64'(wd4), 64'(e4.wd));
            end
        end
        if (!rst && ((|ce3) || (|rs3) || done3 || err3)) begin
            if (q3.size() == 0) begin
                checks++;
                $display("FAIL dut3_unexpected: ce=%b rst=%b done=%b err=%b, none expected",
                         ce3, rs3, done3, err3);
            end else begin
                e3 = q3.pop_front();
                check("dut3_ce", 64'({1'b0, ce3}), 64'(e3.ce));
                check("dut3_rst", 64'({1'b0, rs3}), 64'(e3.rs));
                check("dut3_err", 64'(err3), 64'(e3.err));
                if (e3.ce != 4'b0) check("dut3_wdata", 64'(wd3), 64'(e3.wd));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  a_addr_v [3];
    logic [31:0] a_data_v [3];
    logic [1:0]  b_addr_v [2];
    logic [31:0] b_data_v [2];
    logic        exp_gnt_a [4];
    logic [3:0]  exp_ce [4];
    logic [31:0] exp_wd [4];

    initial begin
        a_addr_v = '{2'd0, 2'd1, 2'd3};
        a_data_v = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002};
        b_addr_v = '{2'd3, 2'd2};
        b_data_v = '{32'h2222_0000, 32'h2222_0001};
        exp_gnt_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_ce    = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};
        exp_wd    = '{32'h1111_0000, 32'h2222_0000, 32'h1111_0001, 32'h2222_0001};

        rst = 1'b1; tb_init = 1'b1;
        a4_valid = 1'b1; a4_addr = 2'd0; a4_data = '0;
        b4_valid = 1'b0; b4_addr = 2'd0; b4_data = '0; clr4 = 1'b0;
        a3_valid = 1'b0; a3_addr = 2'd0; a3_data = '0;
        b3_valid = 1'b0; b3_addr = 2'd0; b3_data = '0; clr3 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 64'(a4_ready), 64'd0);
        check("rst_b_ready", 64'(b4_ready), 64'd0);
        check("rst_ce", 64'(ce4), 64'd0);
        check("rst_rst", 64'(rs4), 64'd0);
        check("rst_wdata", 64'(wd4), 64'd0);
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_done", 64'(done4), 64'd0);
        check("rst_err", 64'(err4), 64'd0);

        next_cycle();
        rst = 1'b0; tb_init = 1'b0; a4_valid = 1'b0;

        // Contention right after reset: A, B, A, B
        begin
            int ia = 0;
            int ib = 0;
            for (int k = 0; k < 4; k++) begin
                a4_valid = 1'b1; a4_addr = a_addr_v[ia]; a4_data = a_data_v[ia];
                b4_valid = 1'b1; b4_addr = b_addr_v[ib]; b4_data = b_data_v[ib];
                @(negedge clk);
                check("cont_a_ready", 64'(a4_ready), 64'(exp_gnt_a[k]));
                check("cont_b_ready", 64'(b4_ready), 64'(!exp_gnt_a[k]));
                push4(exp_ce[k], 4'b0, 1'b0, 1'b0, exp_wd[k]);
                if (exp_gnt_a[k]) ia++; else ib++;
                next_cycle();
            end
        end
        a4_valid = 1'b0; b4_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("cont_reg0", 64'(bank4[0]), 64'h1111_0000);
        check("cont_reg1", 64'(bank4[1]), 64'h1111_0001);
        check("cont_reg2", 64'(bank4[2]), 64'h2222_0001);
        check("cont_reg3", 64'(bank4[3]), 64'h2222_0000);

        // Lone write
        next_cycle();
        a4_valid = 1'b1; a4_addr = 2'd2; a4_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lone_a_ready", 64'(a4_ready), 64'd1);
        check("lone_b_ready", 64'(b4_ready), 64'd0);
        push4(4'b0100, 4'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        a4_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("lone_reg2", 64'(bank4[2]), 64'hDEAD_BEEF);
        check("lone_reg1", 64'(bank4[1]), 64'h1111_0001);

        // Clear with a simultaneous write and a stray clr_req during CLEAR
        next_cycle();
        clr4 = 1'b1; a4_valid = 1'b1; a4_addr = 2'd1; a4_data = 32'h5555_AAAA;
        push4(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0);
        push4(4'b0000, 4'b0010, 1'b0, 1'b0, 32'h0);
        push4(4'b0000, 4'b0100, 1'b0, 1'b0, 32'h0);
        push4(4'b0000, 4'b1000, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("clr_a_ready", 64'(a4_ready), 64'(k == 5));
            check("clr_busy", 64'(busy4), 64'((k >= 1) && (k <= 4)));
            if (k == 5) push4(4'b0010, 4'b0, 1'b0, 1'b0, 32'h5555_AAAA);
            next_cycle();
            clr4 = (k == 1);
            if (k == 5) a4_valid = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) check("clr_reg_init", 64'(bank4[i]), 64'(REG_INIT_VALUE));
        next_cycle();
        @(negedge clk);
        check("clr_post_write", 64'(bank4[1]), 64'h5555_AAAA);

        // Address error on the 3-register instance, then the highest valid index
        next_cycle();
        b3_valid = 1'b1; b3_addr = 2'd3; b3_data = 32'h1234_5678;
        @(negedge clk);
        check("err_b_ready", 64'(b3_ready), 64'd1);
        check("err_a_ready", 64'(a3_ready), 64'd0);
        push3(4'b0000, 1'b1, 32'h1234_5678);
        next_cycle();
        b3_addr = 2'd2; b3_data = 32'hCAFE_0002;
        @(negedge clk);
        check("edge_b_ready", 64'(b3_ready), 64'd1);
        push3(4'b0100, 1'b0, 32'hCAFE_0002);
        next_cycle();
        b3_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("err_reg0", 64'(bank3[0]), 64'(REG_INIT_VALUE));
        check("err_reg1", 64'(bank3[1]), 64'(REG_INIT_VALUE));
        check("edge_reg2", 64'(bank3[2]), 64'hCAFE_0002);

        // Reset during the second CLEAR cycle
        next_cycle();
        clr4 = 1'b1;
        push4(4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0);
        next_cycle();
        clr4 = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rst", 64'(rs4), 64'd0);
        check("mid_rst_busy", 64'(busy4), 64'd0);
        check("mid_rst_done", 64'(done4), 64'd0);
        check("mid_rst_ce", 64'(ce4), 64'd0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_busy", 64'(busy4), 64'd0);
            next_cycle();
        end
        a4_valid = 1'b1; a4_addr = 2'd3; a4_data = 32'h0000_7777;
        @(negedge clk);
        check("post_rst_a_ready", 64'(a4_ready), 64'd1);
        push4(4'b1000, 4'b0, 1'b0, 1'b0, 32'h0000_7777);
        next_cycle();
        a4_valid = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("post_rst_reg3", 64'(bank4[3]), 64'h0000_7777);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q3_drained", 64'(q3.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
